// File: rtl/vga_image_plotter.sv
`timescale 1ns/1ps
// vga_image_plotter
//   Avalon-MM master that copies a WIDTH x HEIGHT image of Q16.16 pixel words
//   from memory to the VGA plot slave, one plot word per on-field pixel.
//   Software programs the source address and screen origin, then writes START.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   csr_*             CSR slave: 0=SRC, 1=ORIGIN {y0[14:8],x0[7:0]},
//                     2=START (write) / {done,busy} (read), 3=plot write count
//   rd_*              memory read master (one read in flight at a time)
//   wr_*              VGA plot write master, address fixed at VGA_ADDR
module vga_image_plotter #(
  parameter int          WIDTH    = 28,
  parameter int          HEIGHT   = 28,
  parameter logic [31:0] VGA_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  csr_address,
  input  logic        csr_read,
  output logic [31:0] csr_readdata,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] rd_address,
  output logic        rd_read,
  input  logic [31:0] rd_readdata,
  input  logic        rd_waitrequest,
  output logic [31:0] wr_address,
  output logic        wr_write,
  output logic [31:0] wr_writedata,
  input  logic        wr_waitrequest
);

  localparam logic [7:0] COL_LAST = 8'(WIDTH - 1);
  localparam logic [6:0] ROW_LAST = 7'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t      state, state_next;

  logic [31:0] src_reg;
  logic [14:0] origin_reg;
  logic        done_reg;
  logic [15:0] count_reg;

  logic [7:0]  x0_run;
  logic [6:0]  y0_run;
  logic [7:0]  col;
  logic [6:0]  row;
  logic [31:0] rd_addr_reg;
  logic [31:0] wr_data_reg;

  logic        busy;
  logic        start;
  logic        last_pixel;
  logic [8:0]  x_sum;
  logic [7:0]  y_sum;
  logic        on_field;
  logic [7:0]  colour;
  logic        rd_done;
  logic        wr_done;
  logic        advance;

  assign start      = csr_write && (csr_address == 2'd2) && (state == IDLE);
  assign last_pixel = (row == ROW_LAST) && (col == COL_LAST);

  // Screen coordinates are one bit wider than the field so that any carry
  // out marks the pixel as off-field.
  assign x_sum    = {1'b0, x0_run} + {1'b0, col};
  assign y_sum    = {1'b0, y0_run} + {1'b0, row};
  assign on_field = !x_sum[8] && !y_sum[7];

  assign rd_done = (state == RD) && !rd_waitrequest;
  assign wr_done = (state == WR) && !wr_waitrequest;
  assign advance = (rd_done && !on_field) || wr_done;

  // Saturate the signed Q16.16 pixel to 8 bits: negatives clamp to black,
  // anything at or above 1.0 clamps to full scale, else the top fraction byte.
  always_comb begin
    colour = rd_readdata[15:8];
    if (rd_readdata[31]) begin
      colour = 8'h00;
    end else if ($signed(rd_readdata) >= 32'sh0001_0000) begin
      colour = 8'hFF;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: an off-field pixel skips WR and goes straight on.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = RD;
      RD: begin
        if (!rd_waitrequest) begin
          if (on_field)        state_next = WR;
          else if (last_pixel) state_next = FIN;
          else                 state_next = RD;
        end
      end
      WR: begin
        if (!wr_waitrequest) begin
          state_next = last_pixel ? FIN : RD;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: requests are pure state decodes so a reset drops them at once.
  always_comb begin
    rd_read  = (state == RD);
    wr_write = (state == WR);
    busy     = (state == RD) || (state == WR);
  end

  assign rd_address   = rd_addr_reg;
  assign wr_writedata = wr_data_reg;
  assign wr_address   = VGA_ADDR;

  // CSR registers. SRC/ORIGIN may be rewritten at any time; the run works
  // from the copies taken at START.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_reg    <= '0;
      origin_reg <= '0;
    end else if (csr_write) begin
      if (csr_address == 2'd0) src_reg    <= csr_writedata;
      if (csr_address == 2'd1) origin_reg <= csr_writedata[14:0];
    end
  end

  // Run datapath. The read address walks linearly, which equals
  // SRC + 4*(row*WIDTH+col) for a row-major image.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_run      <= '0;
      y0_run      <= '0;
      col         <= '0;
      row         <= '0;
      rd_addr_reg <= '0;
      wr_data_reg <= '0;
      count_reg   <= '0;
      done_reg    <= 1'b0;
    end else begin
      if (start) begin
        x0_run      <= origin_reg[7:0];
        y0_run      <= origin_reg[14:8];
        col         <= '0;
        row         <= '0;
        rd_addr_reg <= src_reg;
        count_reg   <= '0;
        done_reg    <= 1'b0;
      end
      if (rd_done && on_field) begin
        wr_data_reg <= {1'b0, y_sum[6:0], x_sum[7:0], 8'h00, colour};
      end
      if (wr_done) begin
        count_reg <= count_reg + 16'd1;
      end
      if (advance) begin
        rd_addr_reg <= rd_addr_reg + 32'd4;
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 7'd1;
        end else begin
          col <= col + 8'd1;
        end
        if (last_pixel) begin
          done_reg <= 1'b1;
        end
      end
    end
  end

  // CSR reads are combinational and return zero when not selected.
  always_comb begin
    csr_readdata = '0;
    if (csr_read) begin
      unique case (csr_address)
        2'd0: csr_readdata = src_reg;
        2'd1: csr_readdata = {17'b0, origin_reg};
        2'd2: csr_readdata = {30'b0, done_reg, busy};
        2'd3: csr_readdata = {16'b0, count_reg};
        default: csr_readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_image_plotter.sv
`timescale 1ns/1ps
// tb_vga_image_plotter
//   Scoreboard bench: each START pushes the expected read addresses and plot
//   words; memory/VGA responder processes pop and compare them as the DUT
//   issues requests, with programmable stall lengths.
module tb_vga_image_plotter;

  localparam int          W   = 28;
  localparam int          H   = 28;
  localparam logic [31:0] VGA = 32'h0400_0000;

  logic        clk;
  logic        reset;
  logic [1:0]  csr_address;
  logic        csr_read;
  logic [31:0] csr_readdata;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic [31:0] rd_address;
  logic        rd_read;
  logic [31:0] rd_readdata;
  logic        rd_waitrequest;
  logic [31:0] wr_address;
  logic        wr_write;
  logic [31:0] wr_writedata;
  logic        wr_waitrequest;

  vga_image_plotter #(.WIDTH(W), .HEIGHT(H), .VGA_ADDR(VGA)) dut (
    .clk            (clk),
    .reset          (reset),
    .csr_address    (csr_address),
    .csr_read       (csr_read),
    .csr_readdata   (csr_readdata),
    .csr_write      (csr_write),
    .csr_writedata  (csr_writedata),
    .rd_address     (rd_address),
    .rd_read        (rd_read),
    .rd_readdata    (rd_readdata),
    .rd_waitrequest (rd_waitrequest),
    .wr_address     (wr_address),
    .wr_write       (wr_write),
    .wr_writedata   (wr_writedata),
    .wr_waitrequest (wr_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks_total;
  int          checks_passed;
  logic [31:0] rd_exp[$];
  logic [31:0] wr_exp[$];
  int          exp_count;
  int          rd_stall, wr_stall;
  int          rd_left, wr_left;
  bit          rd_active, wr_active;
  logic [31:0] rd_hold, wr_hold;
  int          rd_seen;
  logic [31:0] pix_table [8] = '{32'hFFFF_8000, 32'h0000_8000, 32'h0001_0000,
                                 32'h0003_0000, 32'h0000_4C00, 32'h0000_FF00,
                                 32'h8000_0000, 32'h7FFF_FFFF};

  // Compare one observed value with its expected value and tally the result.
  task check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
  endtask

  // Memory contents are a function of address, cycling through the table.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] k;
    k = (a >> 2) ^ (a >> 5);
    return pix_table[k[2:0]];
  endfunction

  function automatic logic [7:0] model_colour(input logic [31:0] p);
    int v;
    v = $signed(p);
    if (v < 0) return 8'h00;
    if (v >= 65536) return 8'hFF;
    return 8'((v >> 8) & 255);
  endfunction

  task csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_address   = a;
    csr_writedata = d;
    csr_write     = 1'b1;
    @(negedge clk);
    csr_write     = 1'b0;
  endtask

  task csr_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    csr_address = a;
    csr_read    = 1'b1;
    #1;
    d        = csr_readdata;
    csr_read = 1'b0;
  endtask

  // Push the expected traffic for a run, program the CSRs and start it.
  task apply_stimulus(input logic [31:0] src, input int x0, input int y0);
    logic [31:0] a;
    logic [6:0]  yy;
    logic [7:0]  xx;
    exp_count = 0;
    rd_seen   = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        a = src + 32'(4 * (r * W + c));
        rd_exp.push_back(a);
        if ((x0 + c) <= 255 && (y0 + r) <= 127) begin
          yy = 7'(y0 + r);
          xx = 8'(x0 + c);
          wr_exp.push_back({1'b0, yy, xx, 8'h00, model_colour(mem_word(a))});
          exp_count++;
        end
      end
    end
    csr_wr(2'd0, src);
    csr_wr(2'd1, 32'((y0 << 8) | x0));
    csr_wr(2'd2, 32'h1);
  endtask

  // Poll status until done (bounded), then check the run's totals.
  task wait_done(input string tag, input int budget);
    logic [31:0] s;
    logic [31:0] n;
    s = '0;
    for (int i = 0; i < budget && !s[1]; i++) csr_rd(2'd2, s);
    check_output({tag, "_status"}, s, 32'h2);
    csr_rd(2'd3, n);
    check_output({tag, "_count"}, n, 32'(exp_count));
    check_output({tag, "_rd_total"}, 32'(rd_seen), 32'(W * H));
    check_output({tag, "_rd_left"}, 32'(rd_exp.size()), 32'h0);
    check_output({tag, "_wr_left"}, 32'(wr_exp.size()), 32'h0);
  endtask

  // Memory and VGA slave models, driven away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      rd_active      = 1'b0;
      wr_active      = 1'b0;
      rd_waitrequest = 1'b0;
      wr_waitrequest = 1'b0;
    end else begin
      if (!rd_read) begin
        rd_active      = 1'b0;
        rd_waitrequest = 1'b0;
      end else begin
        if (!rd_active) begin
          rd_active = 1'b1;
          rd_left   = rd_stall;
          rd_hold   = rd_address;
          rd_seen++;
          check_output("rd_pending", 32'(rd_exp.size() != 0), 32'h1);
          if (rd_exp.size() != 0) check_output("rd_addr", rd_address, rd_exp.pop_front());
        end else begin
          check_output("rd_hold", rd_address, rd_hold);
        end
        if (rd_left > 0) begin
          rd_waitrequest = 1'b1;
          rd_readdata    = 32'hDEAD_BEEF;
          rd_left--;
        end else begin
          rd_waitrequest = 1'b0;
          rd_readdata    = mem_word(rd_address);
          rd_active      = 1'b0;
        end
      end
      if (!wr_write) begin
        wr_active      = 1'b0;
        wr_waitrequest = 1'b0;
      end else begin
        if (!wr_active) begin
          wr_active = 1'b1;
          wr_left   = wr_stall;
          wr_hold   = wr_writedata;
          check_output("wr_pending", 32'(wr_exp.size() != 0), 32'h1);
          if (wr_exp.size() != 0) check_output("wr_data", wr_writedata, wr_exp.pop_front());
        end else begin
          check_output("wr_hold", wr_writedata, wr_hold);
        end
        if (wr_left > 0) begin
          wr_waitrequest = 1'b1;
          wr_left--;
        end else begin
          wr_waitrequest = 1'b0;
          wr_active      = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    bit          seen;
    checks_total   = 0;
    checks_passed  = 0;
    rd_stall       = 0;
    wr_stall       = 0;
    rd_seen        = 0;
    exp_count      = 0;
    reset          = 1'b1;
    csr_address    = '0;
    csr_read       = 1'b0;
    csr_write      = 1'b0;
    csr_writedata  = '0;
    rd_readdata    = '0;
    rd_waitrequest = 1'b0;
    wr_waitrequest = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_output("rst_rd_read", 32'(rd_read), 32'h0);
    check_output("rst_wr_write", 32'(wr_write), 32'h0);
    check_output("rst_rd_address", rd_address, 32'h0);
    check_output("rst_wr_writedata", wr_writedata, 32'h0);
    check_output("wr_address", wr_address, VGA);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      csr_rd(2'(i), d);
      check_output("rst_csr", d, 32'h0);
    end

    // CSR readback.
    csr_wr(2'd0, 32'h1234_5678);
    csr_rd(2'd0, d);
    check_output("csr_src", d, 32'h1234_5678);
    csr_wr(2'd1, 32'hFFFF_FFFF);
    csr_rd(2'd1, d);
    check_output("csr_origin", d, 32'h0000_7FFF);

    // Full image, zero-wait memory and VGA.
    $display("[TB] run A: zero wait");
    apply_stimulus(32'h1000, 10, 5);
    wait_done("runA", 5000);

    // Stalled memory and VGA.
    $display("[TB] run B: stalls");
    rd_stall = 2;
    wr_stall = 3;
    apply_stimulus(32'h2000, 10, 5);
    wait_done("runB", 20000);
    rd_stall = 0;
    wr_stall = 0;

    // Image partially off the field.
    $display("[TB] run C: clipping");
    apply_stimulus(32'h0800, 240, 110);
    wait_done("runC", 5000);
    check_output("runC_expected", 32'(exp_count), 32'd288);

    // START and CSR writes while busy do not disturb the run.
    $display("[TB] run D: writes while busy");
    wr_stall = 1;
    apply_stimulus(32'h3000, 3, 2);
    csr_rd(2'd2, d);
    check_output("runD_busy", d, 32'h1);
    csr_wr(2'd2, 32'h1);
    csr_wr(2'd0, 32'hDEAD_0000);
    csr_wr(2'd1, 32'h0);
    csr_rd(2'd0, d);
    check_output("runD_src_upd", d, 32'hDEAD_0000);
    wait_done("runD", 10000);

    // Reset in the middle of a stalled write.
    $display("[TB] run E: reset mid-write");
    wr_stall = 3;
    apply_stimulus(32'h1000, 10, 5);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = wr_write;
    end
    check_output("runE_saw_write", 32'(seen), 32'h1);
    #2 reset = 1'b1;
    #1;
    check_output("runE_wr_drop", 32'(wr_write), 32'h0);
    check_output("runE_rd_drop", 32'(rd_read), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd_exp.delete();
    wr_exp.delete();
    csr_rd(2'd2, d);
    check_output("runE_status", d, 32'h0);
    csr_rd(2'd3, d);
    check_output("runE_count", d, 32'h0);
    wr_stall = 0;
    apply_stimulus(32'h1000, 10, 5);
    wait_done("runE", 5000);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/vga_image_plotter.md
Name: vga_image_plotter

Overview:
- Avalon-MM master that drives the VGA plot slave's pixel-write interface from memory.
- Software programs a source address and screen origin through a small CSR slave, then starts the block.
- The block reads a WIDTH x HEIGHT image of Q16.16 pixel words from memory and writes one plot word per pixel to the VGA slave.
- Purpose: display DNN input images (e.g. 28x28 digits) without CPU per-pixel writes.

Parameters:
- WIDTH, 28, image columns (1..255).
- HEIGHT, 28, image rows (1..127).
- VGA_ADDR, 32'h0, address of the VGA plot slave on the master write port.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- csr_address  in  2  CSR word select.
- csr_read  in  1  CSR read strobe.
- csr_readdata  out  32  CSR read data.
- csr_write  in  1  CSR write strobe.
- csr_writedata  in  32  CSR write data.
- rd_address  out  32  memory read byte address.
- rd_read  out  1  memory read request.
- rd_readdata  in  32  memory read data.
- rd_waitrequest  in  1  memory stall.
- wr_address  out  32  VGA slave address.
- wr_write  out  1  VGA write request.
- wr_writedata  out  32  plot word.
- wr_waitrequest  in  1  VGA stall.

Behaviour:
- CSR map:
  - 0: SRC, base byte address, R/W.
  - 1: ORIGIN, bits[7:0]=x0, bits[14:8]=y0, R/W.
  - 2: write of any value = START; read = {30'b0, done, busy}.
  - 3: read = number of plot writes issued by the last run (skipped pixels not counted).
- CSR reads are combinational: csr_readdata is valid in the same cycle as csr_read.
- Reset: all CSRs 0, state IDLE, busy=0, done=0, rd_read=0, wr_write=0, rd_address=0, wr_writedata=0. wr_address is constant VGA_ADDR.
- SRC and ORIGIN are snapshotted at START. CSR writes to SRC/ORIGIN while busy update the register only; the run in progress is unaffected.
- START while busy is ignored. START in IDLE clears done and the count, then enters RD.
- FSM states IDLE, RD, WR, FIN:
  - RD: rd_read=1, rd_address = SRC + 4*(row*WIDTH+col). The request and address are held stable while rd_waitrequest=1.
  - In RD, on the first cycle with rd_waitrequest=0, capture rd_readdata and compute the colour.
  - After capture, go to WR if the pixel is on-field, otherwise skip it.
  - WR: wr_write=1 and wr_writedata held stable while wr_waitrequest=1. The write completes on the first cycle with wr_waitrequest=0; the count then increments.
  - Advance: col++ and, on col==WIDTH-1, col=0 and row++. After the last pixel (row==HEIGHT-1, col==WIDTH-1) go to FIN, else back to RD.
  - FIN: one cycle; sets done=1, busy=0, then IDLE.
- busy=1 in RD, WR and FIN-entry, 0 in IDLE.
- Colour saturation on pixel word p (signed Q16.16):
  - p[31]=1 -> 0.
  - p >= 32'h0001_0000 -> 8'hFF.
  - otherwise p[15:8].
- Coordinates: x = x0+col, 9-bit sum; y = y0+row, 8-bit sum.
- Off-field pixels are skipped: x>255 or y>127 means no write and no count.
- Plot word: wr_writedata = {1'b0, y[6:0], x[7:0], 8'h00, colour}.
- Minimum throughput is 2 cycles per pixel with no stalls. No outstanding-read pipelining: exactly one transaction in flight.
- Asynchronous reset mid-run drops any asserted request immediately. The block returns to IDLE with no completion signalled.

Test Plan:
- SRC=0x1000, ORIGIN x0=10,y0=5, START, memory zero-wait:
  - rd_address sequence 0x1000, 0x1004, ..., 0x1C3C (784 reads).
  - First plot word 0x050A_0000 | colour.
  - done=1 and CSR3=784 after the last write.
- Pixel words 0xFFFF_8000, 0x0000_8000, 0x0001_0000, 0x0003_0000 -> colours 0x00, 0x80, 0xFF, 0xFF.
- VGA wr_waitrequest high 3 cycles per write, memory rd_waitrequest high 2 cycles per read:
  - Each request is held constant through its stall.
  - Exactly one write per pixel; no duplicates.
- x0=240, y0=110:
  - Pixels with x>255 or y>127 produce no wr_write.
  - CSR3 = 16*18 = 288.
- START written again while busy -> ignored: same 784 reads, single done.
- Assert reset mid-WR -> wr_write=0 the same cycle. Status reads 0 after reset release; a new START runs a full image correctly.
